// File: rtl/lsq_pkg.sv
// Shared types for the load/store queue issue stage.
//   lsq_entry_t  : one queue slot (program-order memory op)
//   lsq_state_e  : issue FSM states
//   idx_width()  : queue index width for a given entry count
package lsq_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_store;
        logic        size;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic        addr_rdy;
        logic        committed;
    } lsq_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        LD_WAIT,
        LD_WB
    } lsq_state_e;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/lsq_entry_array.sv
// Entry storage for the load/store queue.
// Ports:
//   clk, rstn               clock, async active-low reset
//   flush                   clear every valid bit (beats all other writes)
//   alloc_en/alloc_idx/...  new entry written at the tail slot
//   agu_valid/agu_idx/...   address + store data; ignored for invalid slots
//   commit_en               mark the head committed if it is a valid store
//   pop_en                  retire the head slot
//   head_idx/head_entry     read port for the oldest entry
module lsq_entry_array
    import lsq_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned IDX_W = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             alloc_en,
    input  logic [IDX_W-1:0] alloc_idx,
    input  logic             alloc_is_store,
    input  logic             alloc_size,
    input  logic [31:0]      alloc_pc,
    input  logic             agu_valid,
    input  logic [IDX_W-1:0] agu_idx,
    input  logic [31:0]      agu_addr,
    input  logic [31:0]      agu_data,
    input  logic             commit_en,
    input  logic             pop_en,
    input  logic [IDX_W-1:0] head_idx,
    output lsq_entry_t       head_entry
);

    lsq_entry_t entries [DEPTH];

    assign head_entry = entries[head_idx];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            if (agu_valid && entries[agu_idx].valid) begin
                entries[agu_idx].addr     <= agu_addr;
                entries[agu_idx].data     <= agu_data;
                entries[agu_idx].addr_rdy <= 1'b1;
            end
            if (commit_en && entries[head_idx].valid && entries[head_idx].is_store) begin
                entries[head_idx].committed <= 1'b1;
            end
            if (pop_en) begin
                entries[head_idx].valid <= 1'b0;
            end
            // The tail slot is never valid while allocation is allowed, so
            // this cannot collide with the AGU/commit/pop writes above.
            if (alloc_en) begin
                entries[alloc_idx] <= '{valid:     1'b1,
                                        is_store:  alloc_is_store,
                                        size:      alloc_size,
                                        pc:        alloc_pc,
                                        addr:      '0,
                                        data:      '0,
                                        addr_rdy:  1'b0,
                                        committed: 1'b0};
            end
        end
    end

endmodule

// File: rtl/lsq_mem_issuer.sv
// Load/store queue issue stage: requester side of the data-memory port.
// Ops are held in program order; the oldest issues when ready (loads once
// the address is known, stores once the address is known and committed).
// Ports:
//   clk, rstn, flush                      clock, async reset, pipeline flush
//   alloc_*                               dispatch allocation (alloc_idx = tail)
//   agu_*                                 address / store-data delivery
//   commit_store                          ROB commit of the store at head
//   cache_miss                            miss hint captured with each request
//   mem_*  (out)                          registered memory request
//   mem_rdata, mem_pc_ret                 load return data and PC
//   ld_wb_*                               one-cycle load writeback
module lsq_mem_issuer
    import lsq_pkg::*;
#(
    parameter  int unsigned DEPTH    = 8,
    parameter  int unsigned LOAD_LAT = 1,
    localparam int unsigned IDX_W    = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             alloc_valid,
    input  logic             alloc_is_store,
    input  logic [31:0]      alloc_pc,
    input  logic             alloc_size,
    output logic             alloc_ready,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic             agu_valid,
    input  logic [IDX_W-1:0] agu_idx,
    input  logic [31:0]      agu_addr,
    input  logic [31:0]      agu_data,
    input  logic             commit_store,
    input  logic             cache_miss,
    output logic [31:0]      mem_pc,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_store_size,
    output logic             mem_cache_miss,
    output logic             mem_from_lsq,
    input  logic [31:0]      mem_rdata,
    input  logic [31:0]      mem_pc_ret,
    output logic             ld_wb_valid,
    output logic [IDX_W-1:0] ld_wb_idx,
    output logic [31:0]      ld_wb_pc,
    output logic [31:0]      ld_wb_data,
    output logic             ld_wb_err
);

    localparam logic [IDX_W:0] FULL_COUNT = DEPTH[IDX_W:0];
    localparam logic [2:0]     LAT_INIT   = LOAD_LAT[2:0];

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W:0]   count;
    lsq_state_e       state;
    lsq_state_e       state_next;
    logic [2:0]       ld_cnt;
    logic [2:0]       ld_cnt_next;
    logic             issue_rd;
    logic             issue_wr;
    logic             pop;
    logic             capture;
    logic             alloc_en;
    lsq_entry_t       head_entry;

    assign alloc_ready = (count < FULL_COUNT);
    assign alloc_idx   = tail;
    assign alloc_en    = alloc_valid && alloc_ready && !flush;

    lsq_entry_array #(.DEPTH(DEPTH)) u_entries (
        .clk            (clk),
        .rstn           (rstn),
        .flush          (flush),
        .alloc_en       (alloc_en),
        .alloc_idx      (tail),
        .alloc_is_store (alloc_is_store),
        .alloc_size     (alloc_size),
        .alloc_pc       (alloc_pc),
        .agu_valid      (agu_valid),
        .agu_idx        (agu_idx),
        .agu_addr       (agu_addr),
        .agu_data       (agu_data),
        .commit_en      (commit_store),
        .pop_en         (pop),
        .head_idx       (head),
        .head_entry     (head_entry)
    );

    always_comb begin
        state_next  = state;
        ld_cnt_next = ld_cnt;
        issue_rd    = 1'b0;
        issue_wr    = 1'b0;
        pop         = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (head_entry.valid && head_entry.addr_rdy) begin
                    if (!head_entry.is_store) begin
                        issue_rd    = 1'b1;
                        ld_cnt_next = LAT_INIT;
                        state_next  = LD_WAIT;
                    end else if (head_entry.committed || commit_store) begin
                        issue_wr = 1'b1;
                        pop      = 1'b1;
                    end
                end
            end
            LD_WAIT: begin
                // Counter reaches zero on this edge: data is valid now.
                if (ld_cnt <= 3'd1) begin
                    capture    = 1'b1;
                    pop        = 1'b1;
                    state_next = LD_WB;
                end else begin
                    ld_cnt_next = ld_cnt - 3'd1;
                end
            end
            LD_WB:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            ld_cnt <= '0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
        end else if (flush) begin
            state  <= IDLE;
            ld_cnt <= '0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
        end else begin
            state  <= state_next;
            ld_cnt <= ld_cnt_next;
            if (pop) begin
                head <= head + 1'b1;
            end
            if (alloc_en) begin
                tail <= tail + 1'b1;
            end
            case ({alloc_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_pc         <= '0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_store_size <= 1'b0;
            mem_cache_miss <= 1'b0;
            mem_from_lsq   <= 1'b0;
        end else begin
            mem_read     <= issue_rd && !flush;
            mem_write    <= issue_wr && !flush;
            mem_from_lsq <= (issue_rd || issue_wr) && !flush;
            if ((issue_rd || issue_wr) && !flush) begin
                mem_pc         <= head_entry.pc;
                mem_addr       <= head_entry.addr;
                mem_wdata      <= head_entry.data;
                mem_store_size <= head_entry.size;
                mem_cache_miss <= cache_miss;
            end
        end
    end

    // mem_pc still holds the issued load PC: only one request is in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ld_wb_valid <= 1'b0;
            ld_wb_idx   <= '0;
            ld_wb_pc    <= '0;
            ld_wb_data  <= '0;
            ld_wb_err   <= 1'b0;
        end else begin
            ld_wb_valid <= capture && !flush;
            if (capture && !flush) begin
                ld_wb_idx  <= head;
                ld_wb_pc   <= mem_pc;
                ld_wb_data <= mem_rdata;
                ld_wb_err  <= (mem_pc_ret != mem_pc);
            end
        end
    end

endmodule

// File: tb/tb_lsq_mem_issuer.sv
// Directed bench for lsq_mem_issuer. Two instances share stimulus:
// u_dut (LOAD_LAT=1) is scoreboarded on every request/writeback,
// u_dut3 (LOAD_LAT=3) is checked for load latency and flush behaviour.
module tb_lsq_mem_issuer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_is_store;
    logic [31:0] alloc_pc;
    logic        alloc_size;
    logic        agu_valid;
    logic [2:0]  agu_idx;
    logic [31:0] agu_addr;
    logic [31:0] agu_data;
    logic        commit_store;
    logic        cache_miss;
    logic [31:0] mem_rdata;
    logic [31:0] mem_pc_ret;

    logic        alloc_ready, alloc_ready_3;
    logic [2:0]  alloc_idx, alloc_idx_3;
    logic [31:0] mem_pc, mem_addr, mem_wdata, mem_pc_3, mem_addr_3, mem_wdata_3;
    logic        mem_read, mem_write, mem_store_size, mem_cache_miss, mem_from_lsq;
    logic        mem_read_3, mem_write_3, mem_store_size_3, mem_cache_miss_3, mem_from_lsq_3;
    logic        ld_wb_valid, ld_wb_err, ld_wb_valid_3, ld_wb_err_3;
    logic [2:0]  ld_wb_idx, ld_wb_idx_3;
    logic [31:0] ld_wb_pc, ld_wb_data, ld_wb_pc_3, ld_wb_data_3;

    always #5 clk = ~clk;

    lsq_mem_issuer #(.DEPTH(8), .LOAD_LAT(1)) u_dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_is_store(alloc_is_store),
        .alloc_pc(alloc_pc), .alloc_size(alloc_size),
        .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .agu_valid(agu_valid), .agu_idx(agu_idx), .agu_addr(agu_addr), .agu_data(agu_data),
        .commit_store(commit_store), .cache_miss(cache_miss),
        .mem_pc(mem_pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_store_size(mem_store_size),
        .mem_cache_miss(mem_cache_miss), .mem_from_lsq(mem_from_lsq),
        .mem_rdata(mem_rdata), .mem_pc_ret(mem_pc_ret),
        .ld_wb_valid(ld_wb_valid), .ld_wb_idx(ld_wb_idx), .ld_wb_pc(ld_wb_pc),
        .ld_wb_data(ld_wb_data), .ld_wb_err(ld_wb_err)
    );

    lsq_mem_issuer #(.DEPTH(8), .LOAD_LAT(3)) u_dut3 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_is_store(alloc_is_store),
        .alloc_pc(alloc_pc), .alloc_size(alloc_size),
        .alloc_ready(alloc_ready_3), .alloc_idx(alloc_idx_3),
        .agu_valid(agu_valid), .agu_idx(agu_idx), .agu_addr(agu_addr), .agu_data(agu_data),
        .commit_store(commit_store), .cache_miss(cache_miss),
        .mem_pc(mem_pc_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
        .mem_read(mem_read_3), .mem_write(mem_write_3), .mem_store_size(mem_store_size_3),
        .mem_cache_miss(mem_cache_miss_3), .mem_from_lsq(mem_from_lsq_3),
        .mem_rdata(mem_rdata), .mem_pc_ret(mem_pc_ret),
        .ld_wb_valid(ld_wb_valid_3), .ld_wb_idx(ld_wb_idx_3), .ld_wb_pc(ld_wb_pc_3),
        .ld_wb_data(ld_wb_data_3), .ld_wb_err(ld_wb_err_3)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // kind: 0 = mem_write, 1 = mem_read, 2 = load writeback
    typedef struct {
        int          kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic        size;
        logic        miss;
        logic        err;
        logic [2:0]  idx;
    } exp_t;

    exp_t sbq [$];
    exp_t mon_e;
    int   mon_kind;
    int   wb3_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int kind, input logic [31:0] pc, input logic [31:0] addr,
                            input logic [31:0] data, input logic size, input logic miss,
                            input logic err, input logic [2:0] idx);
        exp_t e;
        e.kind = kind; e.pc = pc; e.addr = addr; e.data = data;
        e.size = size; e.miss = miss; e.err = err; e.idx = idx;
        sbq.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for u_dut.
    always @(negedge clk) begin
        if (rstn && (mem_read || mem_write || ld_wb_valid)) begin
            chk("req_excl", {63'd0, mem_read & mem_write}, 64'd0);
            if (sbq.size() == 0) begin
                chk("unexpected_evt", {61'd0, ld_wb_valid, mem_read, mem_write}, 64'd0);
            end else begin
                mon_e    = sbq.pop_front();
                mon_kind = ld_wb_valid ? 2 : (mem_read ? 1 : 0);
                chk("sb_kind", mon_kind, mon_e.kind);
                if (mon_kind == 2) begin
                    chk("wb_pc",   ld_wb_pc,   mon_e.pc);
                    chk("wb_data", ld_wb_data, mon_e.data);
                    chk("wb_err",  ld_wb_err,  mon_e.err);
                    chk("wb_idx",  ld_wb_idx,  mon_e.idx);
                end else begin
                    chk("req_pc",   mem_pc,         mon_e.pc);
                    chk("req_addr", mem_addr,       mon_e.addr);
                    chk("req_miss", mem_cache_miss, mon_e.miss);
                    chk("req_lsq",  mem_from_lsq,   1);
                    if (mon_kind == 0) begin
                        chk("wr_data", mem_wdata,      mon_e.data);
                        chk("wr_size", mem_store_size, mon_e.size);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && ld_wb_valid_3) wb3_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int got;
        int wait_n;
        int cnt;

        rstn = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_is_store = 1'b0;
        alloc_pc = '0; alloc_size = 1'b0; agu_valid = 1'b0; agu_idx = '0;
        agu_addr = '0; agu_data = '0; commit_store = 1'b0; cache_miss = 1'b0;
        mem_rdata = '0; mem_pc_ret = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {57'd0, mem_read, mem_write, mem_from_lsq, mem_cache_miss,
                         mem_store_size, ld_wb_valid, ld_wb_err}, 64'd0);
        chk("rst_req",   {mem_pc, mem_addr}, 64'd0);
        chk("rst_wdata", {mem_wdata, ld_wb_data}, 64'd0);
        chk("rst_wb",    {29'd0, ld_wb_pc, ld_wb_idx}, 64'd0);
        chk("rst_ready", alloc_ready, 1);
        chk("rst_idx",   alloc_idx, 0);
        @(posedge clk); #1 rstn = 1'b1;
        repeat (10) cyc();
        chk("idle_ready", alloc_ready, 1);

        // Store: address ready, waits for commit, then one write pulse
        alloc_valid = 1'b1; alloc_is_store = 1'b1; alloc_pc = 32'h10; alloc_size = 1'b1;
        chk("st_idx", alloc_idx, 0);
        cyc(); alloc_valid = 1'b0;
        agu_valid = 1'b1; agu_idx = 3'd0; agu_addr = 32'h4; agu_data = 32'h23;
        cyc(); agu_valid = 1'b0;
        repeat (5) cyc();
        push_exp(0, 32'h10, 32'h4, 32'h23, 1'b1, 1'b1, 1'b0, 3'd0);
        commit_store = 1'b1; cache_miss = 1'b1;
        cyc(); commit_store = 1'b0; cache_miss = 1'b0;
        @(negedge clk); chk("st_pulse", mem_write, 1);
        @(negedge clk); chk("st_pulse_end", mem_write, 0);

        // Load, matching returned PC
        mem_rdata = 32'h23; mem_pc_ret = 32'h18;
        @(posedge clk); #1;
        alloc_valid = 1'b1; alloc_is_store = 1'b0; alloc_pc = 32'h18; alloc_size = 1'b0;
        chk("ld_idx", alloc_idx, 1);
        cyc(); alloc_valid = 1'b0;
        push_exp(1, 32'h18, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        push_exp(2, 32'h18, 32'h0, 32'h23, 1'b0, 1'b0, 1'b0, 3'd1);
        agu_valid = 1'b1; agu_idx = 3'd1; agu_addr = 32'h4; agu_data = 32'hffff;
        cyc(); agu_valid = 1'b0;
        got = 0; wait_n = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (mem_read_3) begin got = 1; wait_n = i; end
        end
        chk("ld_issue_seen", got, 1);
        chk("ld_no_bypass", wait_n, 1);
        chk("ld_issue_sync", mem_read, 1);
        @(negedge clk);
        chk("ld_wb_lat1", ld_wb_valid, 1);
        chk("ld3_wb_c1", ld_wb_valid_3, 0);
        @(negedge clk);
        chk("ld_wb_pulse_end", ld_wb_valid, 0);
        chk("ld3_wb_c2", ld_wb_valid_3, 0);
        @(negedge clk);
        chk("ld3_wb_c3", ld_wb_valid_3, 1);
        chk("ld3_data", ld_wb_data_3, 32'h23);
        chk("ld3_err",  ld_wb_err_3, 0);
        chk("ld3_idx",  ld_wb_idx_3, 1);

        // Load, mismatched returned PC
        mem_rdata = 32'h55; mem_pc_ret = 32'h99;
        @(posedge clk); #1;
        alloc_valid = 1'b1; alloc_is_store = 1'b0; alloc_pc = 32'h20;
        chk("ld2_idx", alloc_idx, 2);
        cyc(); alloc_valid = 1'b0;
        push_exp(1, 32'h20, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        push_exp(2, 32'h20, 32'h0, 32'h55, 1'b0, 1'b0, 1'b1, 3'd2);
        agu_valid = 1'b1; agu_idx = 3'd2; agu_addr = 32'h8;
        cyc(); agu_valid = 1'b0;
        repeat (10) cyc();
        chk("ld3_err_mismatch", ld_wb_err_3, 1);

        // Fill across the wrap point, then drain
        for (int i = 0; i < 8; i++) begin
            alloc_valid = 1'b1; alloc_is_store = 1'b1;
            alloc_pc = 32'h100 + 32'(i); alloc_size = i[0];
            chk($sformatf("fill_idx%0d", i), alloc_idx, (3 + i) % 8);
            chk($sformatf("fill_rdy%0d", i), alloc_ready, 1);
            cyc();
        end
        alloc_valid = 1'b0;
        chk("full_ready", alloc_ready, 0);
        alloc_valid = 1'b1; alloc_pc = 32'hdead;
        cyc(); alloc_valid = 1'b0;
        chk("full_idx_hold", alloc_idx, 3);
        commit_store = 1'b1;
        cyc(); commit_store = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_exp(0, 32'h100 + 32'(i), 32'h400 + 32'(4 * i), 32'ha0 + 32'(i),
                     i[0], 1'b0, 1'b0, 3'd0);
        end
        for (int i = 0; i < 8; i++) begin
            agu_valid = 1'b1; agu_idx = 3'((3 + i) % 8);
            agu_addr = 32'h400 + 32'(4 * i); agu_data = 32'ha0 + 32'(i);
            cyc();
        end
        agu_valid = 1'b0;
        commit_store = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cnt += int'(mem_write);
        end
        chk("b2b_writes", cnt, 7);
        @(posedge clk); #1 commit_store = 1'b0;
        repeat (3) cyc();
        chk("drain_ready", alloc_ready, 1);
        chk("drain_idx", alloc_idx, 3);

        // Older store uncommitted blocks a ready younger load
        alloc_valid = 1'b1; alloc_is_store = 1'b1; alloc_pc = 32'h40; alloc_size = 1'b0;
        cyc();
        alloc_is_store = 1'b0; alloc_pc = 32'h44;
        cyc(); alloc_valid = 1'b0;
        agu_valid = 1'b1; agu_idx = 3'd4; agu_addr = 32'h200;
        cyc();
        agu_idx = 3'd3; agu_addr = 32'h204; agu_data = 32'h77;
        cyc(); agu_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cnt += int'(mem_read);
        end
        chk("order_no_read", cnt, 0);
        mem_rdata = 32'habc; mem_pc_ret = 32'h44;
        push_exp(0, 32'h40, 32'h204, 32'h77, 1'b0, 1'b0, 1'b0, 3'd0);
        push_exp(1, 32'h44, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        push_exp(2, 32'h44, 32'h0, 32'habc, 1'b0, 1'b0, 1'b0, 3'd4);
        @(posedge clk); #1 commit_store = 1'b1;
        cyc(); commit_store = 1'b0;
        repeat (12) cyc();

        // Flush while u_dut3 waits on a 3-cycle load
        mem_rdata = 32'h5a5a; mem_pc_ret = 32'h50;
        alloc_valid = 1'b1; alloc_is_store = 1'b0; alloc_pc = 32'h50;
        chk("fl_idx", alloc_idx, 5);
        cyc(); alloc_valid = 1'b0;
        push_exp(1, 32'h50, 32'h300, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
        push_exp(2, 32'h50, 32'h0, 32'h5a5a, 1'b0, 1'b0, 1'b0, 3'd5);
        agu_valid = 1'b1; agu_idx = 3'd5; agu_addr = 32'h300;
        cyc(); agu_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (mem_read_3) got = 1;
        end
        chk("fl_issue_seen", got, 1);
        @(posedge clk); #1 flush = 1'b1;
        cyc(); flush = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cnt += int'(ld_wb_valid_3);
        end
        chk("fl_no_wb", cnt, 0);
        chk("fl_count", u_dut3.count, 0);
        chk("fl_ready", alloc_ready_3, 1);
        @(posedge clk); #1;
        alloc_valid = 1'b1; alloc_is_store = 1'b0; alloc_pc = 32'h60;
        chk("fl_next_idx3", alloc_idx_3, 0);
        chk("fl_next_idx", alloc_idx, 0);
        cyc(); alloc_valid = 1'b0;
        repeat (5) cyc();

        chk("sb_empty", sbq.size(), 0);
        chk("wb3_total", wb3_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
